stack_seq: RTL and testbench
============================

Name: stack_seq

Overview:
- Sequences 6809 PSHS/PSHU/PULS/PULU (and interrupt-entry pushes) onto the dual-ported register block.
- Walks the register-mask postbyte and pulses the block's dec_su/inc_su.
- Reads push data via path_left_addr, writes pulled data via write_reg/write_reg_addr/data_w.
- Runs a byte-wide req/ack memory handshake addressed by the block's reg_su output.

Parameters:
- TIMEOUT, 0, max cycles a mem_req may wait for mem_ack; 0 disables the timeout.

Ports:
- clk_in  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin sequence; sampled only in IDLE
- pull  in  1  0=push, 1=pull; latched at start
- use_s  in  1  1=S stack, 0=U stack; latched at start; driven through to the register block
- mask  in  8  register postbyte; latched at start
- reg_data_i  in  16  path_left_data from the register block
- mem_rdata  in  8  read data, valid with mem_ack
- mem_ack  in  1  completes the current mem_req
- path_left_addr  out  4  register selected for push read
- write_reg  out  1  one-cycle register write strobe
- write_reg_addr  out  4  destination register code
- data_w  out  16  pulled data
- dec_su  out  1  decrement the selected stack pointer
- inc_su  out  1  increment the selected stack pointer
- mem_req  out  1  memory request
- mem_we  out  1  1=write
- mem_wdata  out  8  write byte
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle timeout pulse

Behaviour:
- Register codes: D=0, X=1, Y=2, U=3, S=4, PC=5, A=8, B=9, CC=10, DP=11.
- Mask bit map: b7 PC, b6 other stack (U when use_s=1, S when use_s=0), b5 Y, b4 X, b3 DP, b2 B, b1 A, b0 CC.
- 16-bit entries: b7..b4. 8-bit entries: b3..b0.
- Push order: highest set bit first. Pull order: lowest set bit first.
- Reset: state=IDLE, mask cleared, all outputs 0 (path_left_addr=0, write_reg_addr=0, data_w=0). Reset mid-sequence aborts immediately; no done or err pulse.
- States: IDLE, SCAN, DEC, WR, RD, INC, WB, DONE.
- IDLE: on start, latch pull/use_s/mask, go to SCAN. busy=1 in every state except IDLE.
- SCAN: if the remaining mask is 0, go to DONE. Otherwise select the next bit, set the byte index, clear that mask bit. Push goes to DEC; pull goes to RD.
- DEC: dec_su=1 for exactly 1 cycle, then WR.
- WR: mem_req=1, mem_we=1, held until mem_ack. path_left_addr=current code throughout.
  - 16-bit: first write is reg_data_i[7:0], second is reg_data_i[15:8]. Each byte is preceded by its own DEC.
  - 8-bit: write reg_data_i[7:0].
  - On ack: second byte pending -> DEC; otherwise -> SCAN.
- RD: mem_req=1, mem_we=0, held until mem_ack. mem_rdata is captured on the ack cycle.
  - 16-bit: first byte is the high byte, second is the low byte.
  - Then INC.
- INC: inc_su=1 for 1 cycle. Second byte pending -> RD; otherwise -> WB.
- WB: write_reg=1 for 1 cycle, write_reg_addr=code.
  - data_w={hi,lo} for 16-bit entries, {8'h00,byte} for 8-bit entries.
  - Then SCAN.
- DONE: done=1 for 1 cycle, then IDLE.
- Never more than one of dec_su, inc_su, write_reg is asserted in a cycle. mem_req is 0 in DEC, INC and WB, so reg_su is stable whenever mem_req=1.
- Timeout: when TIMEOUT>0, a counter clears on entry to WR/RD. If it reaches TIMEOUT without ack: err=1 for 1 cycle, go to IDLE, no done. The stack pointer keeps any adjustment already made.
- mem_ack outside WR/RD is ignored. start while busy is ignored.
- Push mask=0x00: start -> SCAN -> DONE -> IDLE; 2 busy cycles, memory untouched.

Test Plan:
- Push CC, S stack, SP=0x0F00, CC=0x55, ack tied 1 -> dec_su at cycle 2; write 0x55 at 0x0EFF at cycle 3; done at cycle 5; SP=0x0EFF.
- PSHS mask=0x81 (PC=0x1234, CC=0xD0), ack=1 -> bytes written at 0x0EFF=0x34, 0x0EFE=0x12, 0x0EFD=0xD0; final SP=0x0EFD; exactly 3 dec_su pulses.
- PULU mask=0x12, U=0x0E00, memory 0x0E00=0x7F, 0x0E01=0xAB, 0x0E02=0xCD -> write_reg A(8) with data_w=0x007F, then X(1) with data_w=0xABCD; U=0x0E03.
- Ack delayed 3 cycles on every byte of PSHU mask=0x40 -> mem_req and mem_we held steady, address stable for 4 cycles per byte; S pushed (code 4); no extra dec_su.
- TIMEOUT=4, ack never asserted on a pull -> err pulses once after 4 req cycles; busy drops; done never asserted; a following start is accepted.
- Reset asserted during WR of a 2-byte push -> next cycle all outputs 0, busy=0; a start issued afterwards runs normally.

Source files
------------

// File: rtl/stack_seq.sv
// -----------------------------------------------------------------------------
// stack_seq
//
// Sequences 6809 stack pushes and pulls (PSHS/PSHU/PULS/PULU and interrupt
// entry pushes) against an external dual-ported register block and a
// byte-wide memory.
//
// The register postbyte is walked one entry at a time:
//   push : highest set bit first, each byte preceded by a stack-pointer
//          decrement, data read from the register block via path_left_addr.
//   pull : lowest set bit first, each byte followed by a stack-pointer
//          increment, assembled data written back via write_reg.
// The memory address is the register block's reg_su output. That address
// only moves on dec_su/inc_su, which never overlap mem_req.
//
// Handshake: mem_req/mem_we/mem_wdata are raised together and held stable
// until the cycle in which mem_ack is sampled high. That cycle completes the
// transfer, and mem_rdata is captured in it. mem_ack is ignored whenever
// no request is outstanding.
//
// Parameters:
//   TIMEOUT        max cycles a request may wait for mem_ack (0 = no limit)
//
// Ports:
//   clk_in         clock
//   reset          synchronous active-high reset
//   start          begin a sequence (sampled only while idle)
//   pull           0 = push, 1 = pull (latched at start)
//   use_s          1 = S stack, 0 = U stack (latched at start)
//   mask           register postbyte (latched at start)
//   reg_data_i     path_left_data from the register block
//   mem_rdata      memory read data, valid with mem_ack
//   mem_ack        completes the current mem_req
//   path_left_addr register code selected for the push read
//   write_reg      one-cycle register write strobe
//   write_reg_addr destination register code
//   data_w         pulled register value
//   dec_su         decrement the selected stack pointer
//   inc_su         increment the selected stack pointer
//   mem_req        memory request
//   mem_we         1 = write
//   mem_wdata      write byte
//   busy           sequence in progress
//   done           one-cycle completion pulse
//   err            one-cycle timeout pulse
// -----------------------------------------------------------------------------
module stack_seq #(
    parameter int TIMEOUT = 0
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        start,
    input  logic        pull,
    input  logic        use_s,
    input  logic [7:0]  mask,
    input  logic [15:0] reg_data_i,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [3:0]  path_left_addr,
    output logic        write_reg,
    output logic [3:0]  write_reg_addr,
    output logic [15:0] data_w,
    output logic        dec_su,
    output logic        inc_su,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DEC,
        S_WR,
        S_RD,
        S_INC,
        S_WB,
        S_DONE
    } state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t          state;
    logic            pull_q;
    logic            use_s_q;
    logic [7:0]      mask_q;     // entries still to be transferred
    logic            is16;       // current entry is a 16-bit register
    logic            second;     // working on the second byte of a 16-bit entry
    logic [7:0]      hi_byte;
    logic [7:0]      lo_byte;
    logic [TW-1:0]   tmo_cnt;
    logic [2:0]      sel_bit;
    logic            tmo_hit;

    // Postbyte bit -> register code. Bit 6 names the stack NOT being used.
    function automatic logic [3:0] code_of(input logic [2:0] b, input logic s);
        logic [3:0] c;
        case (b)
            3'd7:    c = 4'd5;                   // PC
            3'd6:    c = s ? 4'd3 : 4'd4;        // U on S stack, S on U stack
            3'd5:    c = 4'd2;                   // Y
            3'd4:    c = 4'd1;                   // X
            3'd3:    c = 4'd11;                  // DP
            3'd2:    c = 4'd9;                   // B
            3'd1:    c = 4'd8;                   // A
            default: c = 4'd10;                  // CC
        endcase
        return c;
    endfunction

    // Next entry to transfer: the last match in each loop wins, so the
    // descending loop finds the lowest set bit (pull) and the ascending
    // loop the highest (push).
    always_comb begin
        sel_bit = 3'd0;
        if (pull_q) begin
            for (int i = 7; i >= 0; i--) begin
                if (mask_q[i]) sel_bit = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (mask_q[i]) sel_bit = 3'(i);
            end
        end
    end

    // The counter clears on entry to WR/RD, so the request has been up for
    // tmo_cnt+1 cycles when this is evaluated.
    assign tmo_hit = (TIMEOUT > 0) && (int'(tmo_cnt) >= TIMEOUT - 1);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state          <= S_IDLE;
            pull_q         <= 1'b0;
            use_s_q        <= 1'b0;
            mask_q         <= 8'h00;
            is16           <= 1'b0;
            second         <= 1'b0;
            hi_byte        <= 8'h00;
            lo_byte        <= 8'h00;
            tmo_cnt        <= '0;
            path_left_addr <= 4'd0;
            write_reg      <= 1'b0;
            write_reg_addr <= 4'd0;
            data_w         <= 16'h0000;
            dec_su         <= 1'b0;
            inc_su         <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_wdata      <= 8'h00;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            // Single-cycle strobes default low.
            dec_su    <= 1'b0;
            inc_su    <= 1'b0;
            write_reg <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        pull_q  <= pull;
                        use_s_q <= use_s;
                        mask_q  <= mask;
                        busy    <= 1'b1;
                        state   <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (mask_q == 8'h00) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        mask_q[sel_bit] <= 1'b0;
                        // path_left_addr doubles as the current register
                        // code, so the push data is already valid in DEC.
                        path_left_addr  <= code_of(sel_bit, use_s_q);
                        is16            <= sel_bit[2];
                        second          <= 1'b0;
                        if (pull_q) begin
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                            tmo_cnt <= '0;
                            state   <= S_RD;
                        end else begin
                            dec_su <= 1'b1;
                            state  <= S_DEC;
                        end
                    end
                end

                S_DEC: begin
                    // Low byte goes out first, then the high byte.
                    mem_wdata <= second ? reg_data_i[15:8] : reg_data_i[7:0];
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    tmo_cnt   <= '0;
                    state     <= S_WR;
                end

                S_WR: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (is16 && !second) begin
                            second <= 1'b1;
                            dec_su <= 1'b1;
                            state  <= S_DEC;
                        end else begin
                            state <= S_SCAN;
                        end
                    end else if (tmo_hit) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                S_RD: begin
                    if (mem_ack) begin
                        // Lower address holds the high byte of a 16-bit entry.
                        if (is16 && !second) hi_byte <= mem_rdata;
                        else                 lo_byte <= mem_rdata;
                        mem_req <= 1'b0;
                        inc_su  <= 1'b1;
                        state   <= S_INC;
                    end else if (tmo_hit) begin
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                S_INC: begin
                    if (is16 && !second) begin
                        second  <= 1'b1;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= S_RD;
                    end else begin
                        write_reg      <= 1'b1;
                        write_reg_addr <= path_left_addr;
                        data_w         <= is16 ? {hi_byte, lo_byte} : {8'h00, lo_byte};
                        state          <= S_WB;
                    end
                end

                S_WB: begin
                    state <= S_SCAN;
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_seq.sv
// -----------------------------------------------------------------------------
// tb_stack_seq
//
// Drives stack_seq against a behavioural register block and a 64 KiB memory.
// The expected event stream of every sequence (stack-pointer pulses, memory
// transfers, register writes, completion) is derived from the postbyte rules
// and queued; an independent monitor pops and compares on every DUT event.
// -----------------------------------------------------------------------------
module tb_stack_seq;

    localparam int TIMEOUT = 4;

    localparam int K_DEC = 1;
    localparam int K_INC = 2;
    localparam int K_MW  = 3;
    localparam int K_MR  = 4;
    localparam int K_RW  = 5;
    localparam int K_DN  = 6;
    localparam int K_ERR = 7;

    // ---------------- clock / reset / DUT ----------------
    logic        clk_in = 1'b0;
    logic        reset;
    logic        start;
    logic        pull;
    logic        use_s;
    logic [7:0]  mask;
    logic [15:0] reg_data_i;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [3:0]  path_left_addr;
    logic        write_reg;
    logic [3:0]  write_reg_addr;
    logic [15:0] data_w;
    logic        dec_su;
    logic        inc_su;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk_in = ~clk_in;

    stack_seq #(.TIMEOUT(TIMEOUT)) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .start          (start),
        .pull           (pull),
        .use_s          (use_s),
        .mask           (mask),
        .reg_data_i     (reg_data_i),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .path_left_addr (path_left_addr),
        .write_reg      (write_reg),
        .write_reg_addr (write_reg_addr),
        .data_w         (data_w),
        .dec_su         (dec_su),
        .inc_su         (inc_su),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    // ---------------- scoreboard state ----------------
    logic [39:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    // ---------------- register block + memory model ----------------
    logic [15:0] reg_file [0:15];
    logic [7:0]  mem [0:65535];
    logic [15:0] reg_su;
    logic        tb_use_s = 1'b0;
    logic        mem_inited = 1'b0;
    logic        pre_reg_en = 1'b0;
    logic [3:0]  pre_code = 4'd0;
    logic [15:0] pre_val = 16'h0;
    logic        pre_mem_en = 1'b0;
    logic [15:0] pre_addr = 16'h0;
    logic [7:0]  pre_data = 8'h0;

    assign reg_su     = tb_use_s ? reg_file[4] : reg_file[3];
    assign reg_data_i = reg_file[path_left_addr];

    always @(posedge clk_in) begin
        if (!mem_inited) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'($urandom);
            for (int i = 0; i < 16; i++) reg_file[i] <= 16'($urandom);
            mem_inited <= 1'b1;
        end else begin
            if (pre_reg_en) reg_file[pre_code] <= pre_val;
            if (pre_mem_en) mem[pre_addr] <= pre_data;
            if (mem_req && mem_ack && mem_we) mem[reg_su] <= mem_wdata;
            if (dec_su) begin
                if (tb_use_s) reg_file[4] <= reg_file[4] - 16'd1;
                else          reg_file[3] <= reg_file[3] - 16'd1;
            end
            if (inc_su) begin
                if (tb_use_s) reg_file[4] <= reg_file[4] + 16'd1;
                else          reg_file[3] <= reg_file[3] + 16'd1;
            end
            if (write_reg) reg_file[write_reg_addr] <= data_w;
        end
    end

    // ---------------- memory responder ----------------
    int delay_mode = 0;     // <0: random 0..3 cycles, else fixed delay
    logic no_ack = 1'b0;
    int wait_cnt = 0;
    int cur_delay = 0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk_in);
            if (mem_req && !reset) begin
                if (wait_cnt == 0)
                    cur_delay = (delay_mode < 0) ? int'($urandom_range(0, 3)) : delay_mode;
                if (!no_ack && wait_cnt >= cur_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[reg_su];
                    wait_cnt  = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 8'($urandom);
                    wait_cnt++;
                end
            end else begin
                // Stray acks with no request outstanding must be ignored.
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = 8'($urandom);
                wait_cnt  = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [39:0] mk_ev(input int kind, input logic [15:0] a, input logic [15:0] d);
        return {8'(kind), a, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input logic [39:0] act);
        logic [39:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: got event %h with nothing expected", name, act);
        end else begin
            e = exp_q.pop_front();
            if (e !== act) begin
                bad++;
                $display("FAIL %s: got event %h expected %h", name, act, e);
            end
        end
    endtask

    task automatic preset_reg(input logic [3:0] code, input logic [15:0] val);
        @(negedge clk_in);
        pre_code = code; pre_val = val; pre_reg_en = 1'b1;
        @(posedge clk_in); #1;
        pre_reg_en = 1'b0;
    endtask

    task automatic preset_mem(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk_in);
        pre_addr = a; pre_data = d; pre_mem_en = 1'b1;
        @(posedge clk_in); #1;
        pre_mem_en = 1'b0;
    endtask

    // ---------------- monitor ----------------
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [24:0] prev_bus = '0;

    initial begin
        forever begin
            @(negedge clk_in); #2;
            if (mem_req && prev_req && !prev_ack)
                chk("req_stable", {reg_su, mem_we, mem_wdata}, prev_bus);
            prev_req = mem_req;
            prev_ack = mem_ack;
            prev_bus = {reg_su, mem_we, mem_wdata};
            if (dec_su) sb_check("dec_su", mk_ev(K_DEC, 16'h0, 16'h0));
            if (inc_su) sb_check("inc_su", mk_ev(K_INC, 16'h0, 16'h0));
            if (mem_req && mem_ack) begin
                if (mem_we) sb_check("mem_write", mk_ev(K_MW, reg_su, {8'h00, mem_wdata}));
                else        sb_check("mem_read", mk_ev(K_MR, reg_su, 16'h0));
            end
            if (write_reg) sb_check("write_reg", mk_ev(K_RW, {12'h0, write_reg_addr}, data_w));
            if (done) sb_check("done", mk_ev(K_DN, 16'h0, 16'h0));
            if (err)  sb_check("err", mk_ev(K_ERR, 16'h0, 16'h0));
        end
    end

    // ---------------- reference model ----------------
    // Postbyte bit -> register code; bit 6 is the opposite stack pointer.
    function automatic logic [3:0] reg_code(input int b, input logic us);
        logic [3:0] tab [0:7];
        tab = '{4'd10, 4'd8, 4'd9, 4'd11, 4'd1, 4'd2, 4'd0, 4'd5};
        if (b == 6) return us ? 4'd3 : 4'd4;
        return tab[b];
    endfunction

    task automatic model(input logic p, input logic us, input logic [7:0] m, output logic [15:0] sp_out);
        logic [15:0] sp;
        logic [15:0] val;
        logic [3:0]  code;
        logic [7:0]  hi;
        logic [7:0]  lo;
        sp = us ? reg_file[4] : reg_file[3];
        if (!p) begin
            for (int b = 7; b >= 0; b--) begin
                if (m[b]) begin
                    code = reg_code(b, us);
                    val  = reg_file[code];
                    exp_q.push_back(mk_ev(K_DEC, 16'h0, 16'h0));
                    sp = sp - 16'd1;
                    exp_q.push_back(mk_ev(K_MW, sp, {8'h00, val[7:0]}));
                    if (b >= 4) begin
                        exp_q.push_back(mk_ev(K_DEC, 16'h0, 16'h0));
                        sp = sp - 16'd1;
                        exp_q.push_back(mk_ev(K_MW, sp, {8'h00, val[15:8]}));
                    end
                end
            end
        end else begin
            for (int b = 0; b < 8; b++) begin
                if (m[b]) begin
                    code = reg_code(b, us);
                    if (b >= 4) begin
                        hi = mem[sp];
                        exp_q.push_back(mk_ev(K_MR, sp, 16'h0));
                        exp_q.push_back(mk_ev(K_INC, 16'h0, 16'h0));
                        sp = sp + 16'd1;
                        lo = mem[sp];
                        exp_q.push_back(mk_ev(K_MR, sp, 16'h0));
                        exp_q.push_back(mk_ev(K_INC, 16'h0, 16'h0));
                        sp = sp + 16'd1;
                        exp_q.push_back(mk_ev(K_RW, {12'h0, code}, {hi, lo}));
                    end else begin
                        lo = mem[sp];
                        exp_q.push_back(mk_ev(K_MR, sp, 16'h0));
                        exp_q.push_back(mk_ev(K_INC, 16'h0, 16'h0));
                        sp = sp + 16'd1;
                        exp_q.push_back(mk_ev(K_RW, {12'h0, code}, {8'h00, lo}));
                    end
                end
            end
        end
        exp_q.push_back(mk_ev(K_DN, 16'h0, 16'h0));
        sp_out = sp;
    endtask

    // ---------------- driver ----------------
    int r_done, r_busy, r_dec, r_first_dec, r_req, r_first_req, r_err;

    task automatic run_seq(input logic p, input logic us, input logic [7:0] m, input logic exp_to);
        logic [15:0] exp_sp;
        logic        finished;
        if (exp_to) begin
            exp_sp = us ? reg_file[4] : reg_file[3];
            exp_q.push_back(mk_ev(K_ERR, 16'h0, 16'h0));
        end else begin
            model(p, us, m, exp_sp);
        end
        r_done = 0; r_busy = 0; r_dec = 0; r_first_dec = 0;
        r_req = 0; r_first_req = 0; r_err = 0; finished = 1'b0;
        @(negedge clk_in);
        tb_use_s = us; pull = p; use_s = us; mask = m; start = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0; pull = 1'($urandom); use_s = 1'($urandom); mask = 8'($urandom);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk_in);
            if (k == 2) start = 1'b1;   // must be ignored while busy
            if (k == 3) start = 1'b0;
            if (busy) r_busy++;
            if (dec_su) begin r_dec++; if (r_first_dec == 0) r_first_dec = k; end
            if (mem_req) begin r_req++; if (r_first_req == 0) r_first_req = k; end
            if (done && r_done == 0) r_done = k;
            if (err) r_err++;
            if (!busy) begin finished = 1'b1; break; end
        end
        chk("run_bound", 64'(finished), 64'd1);
        #3;
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        chk("final_sp", 64'(us ? reg_file[4] : reg_file[3]), 64'(exp_sp));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic found;
        reset = 1'b1; start = 1'b0; pull = 1'b0; use_s = 1'b0; mask = 8'h00;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("reset_outputs", {path_left_addr, write_reg, write_reg_addr, data_w, dec_su, inc_su,
                              mem_req, mem_we, mem_wdata, busy, done, err}, 64'h0);
        reset = 1'b0;

        // Push CC on S with ack tied high: cycle-exact timing.
        delay_mode = 0;
        preset_reg(4'd4, 16'h0F00);
        preset_reg(4'd10, 16'h0055);
        run_seq(1'b0, 1'b1, 8'h01, 1'b0);
        chk("t1_dec_cycle", 64'(r_first_dec), 64'd2);
        chk("t1_wr_cycle", 64'(r_first_req), 64'd3);
        chk("t1_done_cycle", 64'(r_done), 64'd5);
        chk("t1_mem", 64'(mem[16'h0EFF]), 64'h55);
        chk("t1_sp", 64'(reg_file[4]), 64'h0EFF);

        // PSHS PC,CC.
        preset_reg(4'd4, 16'h0F00);
        preset_reg(4'd5, 16'h1234);
        preset_reg(4'd10, 16'h00D0);
        run_seq(1'b0, 1'b1, 8'h81, 1'b0);
        chk("t2_mem_eff", 64'(mem[16'h0EFF]), 64'h34);
        chk("t2_mem_efe", 64'(mem[16'h0EFE]), 64'h12);
        chk("t2_mem_efd", 64'(mem[16'h0EFD]), 64'hD0);
        chk("t2_sp", 64'(reg_file[4]), 64'h0EFD);
        chk("t2_dec_count", 64'(r_dec), 64'd3);

        // PULU A,X.
        preset_reg(4'd3, 16'h0E00);
        preset_mem(16'h0E00, 8'h7F);
        preset_mem(16'h0E01, 8'hAB);
        preset_mem(16'h0E02, 8'hCD);
        run_seq(1'b1, 1'b0, 8'h12, 1'b0);
        chk("t3_a", 64'(reg_file[8]), 64'h007F);
        chk("t3_x", 64'(reg_file[1]), 64'hABCD);
        chk("t3_u", 64'(reg_file[3]), 64'h0E03);

        // PSHU S with every ack delayed 3 cycles.
        delay_mode = 3;
        preset_reg(4'd3, 16'h0E80);
        preset_reg(4'd4, 16'hBEEF);
        run_seq(1'b0, 1'b0, 8'h40, 1'b0);
        chk("t4_req_cycles", 64'(r_req), 64'd8);
        chk("t4_dec_count", 64'(r_dec), 64'd2);
        chk("t4_mem_lo", 64'(mem[16'h0E7F]), 64'hEF);
        chk("t4_mem_hi", 64'(mem[16'h0E7E]), 64'hBE);

        // Empty push mask.
        delay_mode = 0;
        run_seq(1'b0, 1'b1, 8'h00, 1'b0);
        chk("t5_busy_cycles", 64'(r_busy), 64'd2);
        chk("t5_req_cycles", 64'(r_req), 64'd0);

        // Timeout on a pull, then a normal start.
        no_ack = 1'b1;
        preset_reg(4'd4, 16'h0F00);
        run_seq(1'b1, 1'b1, 8'h01, 1'b1);
        chk("t6_err_pulses", 64'(r_err), 64'd1);
        chk("t6_req_cycles", 64'(r_req), 64'd4);
        chk("t6_no_done", 64'(r_done), 64'd0);
        no_ack = 1'b0;
        run_seq(1'b1, 1'b1, 8'h01, 1'b0);
        chk("t6_restart_done", 64'(r_done != 0), 64'd1);

        // Reset during the first WR of a 2-byte push.
        delay_mode = 3;
        preset_reg(4'd4, 16'h0F00);
        @(negedge clk_in);
        tb_use_s = 1'b1; pull = 1'b0; use_s = 1'b1; mask = 8'h80; start = 1'b1;
        exp_q.push_back(mk_ev(K_DEC, 16'h0, 16'h0));
        @(posedge clk_in); #1;
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            if (mem_req) begin found = 1'b1; break; end
        end
        chk("t7_reached_wr", 64'(found), 64'd1);
        reset = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        chk("t7_reset_outputs", {path_left_addr, write_reg, write_reg_addr, data_w, dec_su, inc_su,
                                 mem_req, mem_we, mem_wdata, busy, done, err}, 64'h0);
        reset = 1'b0;
        #3;
        exp_q.delete();
        run_seq(1'b0, 1'b1, 8'h80, 1'b0);
        chk("t7_restart_done", 64'(r_done != 0), 64'd1);

        // Randomized sequences with random ack latency.
        delay_mode = -1;
        for (int it = 0; it < 40; it++) begin
            preset_reg(4'd3, 16'($urandom));
            preset_reg(4'd4, 16'($urandom));
            run_seq(1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
